multiplicador_seq_param: RTL and testbench

Parametrised sequential shift-and-add multiplier with start/busy/done handshake, WIDTH-bit operands, a runtime unsigned/signed mode select and a full 2*WIDTH-bit product. Also produces a WIDTH-bit result with overflow detection, truncated or saturated depending on build option. Instantiated by the ULA as its multiply unit and replaces the fixed 8-bit multiplier. Default WIDTH = 8.

---
 rtl/multiplicador_seq_param.sv | 137 +++++++++++++
 tb/tb_multiplicador_seq_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq_param.sv
// Sequential shift-and-add multiplier, WIDTH-bit operands, unsigned/signed mode, 2*WIDTH-bit product.
// Build option MULT_SAT_EN: reduced result saturates on overflow instead of wrapping.
module multiplicador_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sinal,
    input  logic [WIDTH-1:0]   multiplicando,
    input  logic [WIDTH-1:0]   multiplicador,
    output logic [2*WIDTH-1:0] produto_full,
    output logic [WIDTH-1:0]   produto,
    output logic               overflow,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is sampled only while busy=0 (IDLE); once accepted, busy
    // stays high through CALC and FIX, and done pulses for one cycle as the
    // registered results appear. A start seen while busy=1 is dropped, never queued.
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state;
    state_t               state_next;
    logic                 sign_res;
    logic                 mode_signed;
    logic [WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]     mult_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   full_next;
    logic                 ovf_next;
    logic [WIDTH-1:0]     prod_next;
    logic                 upper_ones;
    logic                 upper_zeros;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (count == CW'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Signed operands are reduced to magnitudes; the most negative value maps to 2^(W-1).
    always_comb begin
        a_neg = sinal & multiplicando[WIDTH-1];
        b_neg = sinal & multiplicador[WIDTH-1];
        mag_a = a_neg ? -multiplicando : multiplicando;
        mag_b = b_neg ? -multiplicador : multiplicador;
    end

    always_comb begin
        full_next   = sign_res ? -acc : acc;
        upper_ones  = &full_next[2*WIDTH-1:WIDTH-1];
        upper_zeros = ~|full_next[2*WIDTH-1:WIDTH-1];
        if (mode_signed) begin
            ovf_next = ~(upper_ones | upper_zeros);
        end else begin
            ovf_next = |full_next[2*WIDTH-1:WIDTH];
        end
        prod_next = full_next[WIDTH-1:0];
`ifdef MULT_SAT_EN
        if (ovf_next) begin
            if (!mode_signed) begin
                prod_next = {WIDTH{1'b1}};
            end else if (sign_res) begin
                prod_next = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                prod_next = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_res     <= 1'b0;
            mode_signed  <= 1'b0;
            mcand_reg    <= '0;
            mult_reg     <= '0;
            acc          <= '0;
            count        <= '0;
            produto_full <= '0;
            produto      <= '0;
            overflow     <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_res    <= sinal & (multiplicando[WIDTH-1] ^ multiplicador[WIDTH-1]);
                        mode_signed <= sinal;
                        mcand_reg   <= mag_a;
                        mult_reg    <= mag_b;
                        acc         <= '0;
                        count       <= '0;
                    end
                end
                CALC: begin
                    if (mult_reg[0]) begin
                        acc <= acc + ({{WIDTH{1'b0}}, mcand_reg} << count);
                    end
                    mult_reg <= mult_reg >> 1;
                    count    <= count + 1'b1;
                end
                FIX: begin
                    produto_full <= full_next;
                    produto      <= prod_next;
                    overflow     <= ovf_next;
                    done         <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplicador_seq_param.sv
// Self-checking bench for multiplicador_seq_param: scoreboard of expected products checked on done.
module tb_multiplicador_seq_param;
    localparam int W  = 8;
    localparam int EW = 3 * W + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           sinal;
    logic [W-1:0]   multiplicando;
    logic [W-1:0]   multiplicador;
    logic [2*W-1:0] produto_full;
    logic [W-1:0]   produto;
    logic           overflow;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    logic [EW-1:0]  exp_q[$];
    int             cyc_q[$];
    logic [2*W-1:0] last_full = '0;
    logic [W-1:0]   last_prod = '0;
    logic           last_ovf  = 1'b0;

    multiplicador_seq_param #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sinal         (sinal),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .produto_full  (produto_full),
        .produto       (produto),
        .overflow      (overflow),
        .busy          (busy),
        .done          (done)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // reference model: exact integer product, then range check and reduction
    function automatic logic [EW-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa, pb, p;
        logic [2*W-1:0] full;
        logic [W-1:0]   red;
        logic           ovf;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        full = p[2*W-1:0];
        if (s) ovf = (p < -(longint'(1) << (W - 1))) || (p > (longint'(1) << (W - 1)) - 1);
        else   ovf = (p >= (longint'(1) << W));
        red = full[W-1:0];
`ifdef MULT_SAT_EN
        if (ovf) begin
            if (!s)        red = {W{1'b1}};
            else if (p < 0) red = {1'b1, {(W-1){1'b0}}};
            else           red = {1'b0, {(W-1){1'b1}}};
        end
`endif
        return {ovf, red, full};
    endfunction

    // driver: waits for idle, presents one request, records expectation at the accepting edge
    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int acc_cycle;
        bit idle_seen;
        idle_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_seen = 1;
                break;
            end
        end
        if (!idle_seen) check("wait_idle", 0, 1);
        sinal         = s;
        multiplicando = a;
        multiplicador = b;
        start         = 1'b1;
        acc_cycle     = cycle + 1;
        @(posedge clk);
        exp_q.push_back(model(s, a, b));
        cyc_q.push_back(acc_cycle);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // scoreboard / monitor, sampled 1 time unit after the active edge
    always @(posedge clk) begin
        logic [EW-1:0] e;
        int c;
        #1;
        if (done) begin
            check("busy_at_done", busy, 0);
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("latency", cycle - c, W + 1);
                check("produto_full", produto_full, e[2*W-1:0]);
                check("produto", produto, e[3*W-1:2*W]);
                check("overflow", overflow, e[3*W]);
                last_full = e[2*W-1:0];
                last_prod = e[3*W-1:2*W];
                last_ovf  = e[3*W];
            end
        end else if (busy) begin
            check("hold_full", produto_full, last_full);
            check("hold_prod", {produto, overflow}, {last_prod, last_ovf});
        end
    end

    initial begin
        bit drained;
        rst = 1'b1;
        start = 1'b0;
        sinal = 1'b0;
        multiplicando = '0;
        multiplicador = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {produto_full, produto, overflow, busy, done}, '0);
        rst = 1'b0;

        start_op(0, 8'd13, 8'd11, 0);
        start_op(0, 8'd200, 8'd3, 0);
        start_op(1, 8'hF9, 8'd6, 0);
        start_op(1, 8'h80, 8'h80, 0);

        // start held high; operand changes during CALC must be ignored
        start_op(0, 8'd10, 8'd20, 1);
        repeat (3) @(negedge clk);
        multiplicando = 8'd99;
        multiplicador = 8'd77;
        sinal = 1'b1;
        start_op(0, 8'd3, 8'd4, 0);

        // abort mid-CALC: outputs clear at once, no done for the aborted request
        start_op(0, 8'd9, 8'd9, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        last_full = '0;
        last_prod = '0;
        last_ovf  = 1'b0;
        #1;
        check("async_reset", {produto_full, produto, overflow, busy, done}, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        start_op(0, 8'd5, 8'd5, 0);

        start_op(0, 8'd0, 8'd255, 0);
        start_op(0, 8'd255, 8'd255, 0);

        for (int i = 0; i < 10; i++) begin
            start_op(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                     W'($urandom_range(0, 255)), 0);
        end

        drained = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                drained = 1;
                break;
            end
        end
        check("drain", drained, 1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
